// File: rtl/jtpopeye_romrq_if.sv
// CPU-side and SDRAM-side signal bundle for the Popeye ROM fetch bridge.
// The bridge uses the slave modport; the CPU/SDRAM side uses master.
interface jtpopeye_romrq_if #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 8,
  parameter int unsigned LINE_BYTES = 4
);
  localparam int unsigned LB = $clog2(LINE_BYTES);

  logic                       cs;
  logic [AW-1:0]              addr;
  logic [DW-1:0]              dout;
  logic                       wait_n;
  logic                       flush;
  logic                       sdram_req;
  logic [AW-LB-1:0]           sdram_addr;
  logic                       data_ok;
  logic [LINE_BYTES*DW-1:0]   sdram_data;

  modport slave (
    input  cs, addr, flush, data_ok, sdram_data,
    output dout, wait_n, sdram_req, sdram_addr
  );

  modport master (
    output cs, addr, flush, data_ok, sdram_data,
    input  dout, wait_n, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtpopeye_romrq.sv
// ROM fetch bridge: one-line tagged buffer in front of the shared SDRAM ROM port.
// A miss stalls the CPU via wait_n while a full line is fetched.
module jtpopeye_romrq #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 8,
  parameter int unsigned LINE_BYTES = 4,
  parameter int unsigned DESCRAMBLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  jtpopeye_romrq_if.slave   bus
);
  localparam int unsigned LB = $clog2(LINE_BYTES);
  localparam int unsigned TW = AW - LB;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                           r_state;
  logic                             r_valid;
  logic                             r_drop;
  logic                             r_req;
  logic [TW-1:0]                    r_tag;
  logic [TW-1:0]                    r_sdram_addr;
  logic [LINE_BYTES-1:0][DW-1:0]    r_line;

  logic                             w_hit;
  logic [DW-1:0]                    w_byte;

  assign w_hit          = r_valid && (bus.addr[AW-1:LB] == r_tag);
  assign bus.wait_n     = !bus.cs || w_hit;
  assign bus.sdram_req  = r_req;
  assign bus.sdram_addr = r_sdram_addr;

  // Byte select within the buffered line, little-endian
  generate
    if (LB == 0) begin : g_one_byte
      assign w_byte = r_line[0];
    end else begin : g_byte_sel
      logic [LB-1:0] w_ofs;
      assign w_ofs  = bus.addr[LB-1:0];
      assign w_byte = r_line[w_ofs];
    end
  endgenerate

  // Board ROM data-line permutation
  generate
    if (DESCRAMBLE != 0 && DW == 8) begin : g_descramble
      assign bus.dout = {w_byte[3], w_byte[4], w_byte[2], w_byte[5],
                         w_byte[1], w_byte[6], w_byte[0], w_byte[7]};
    end else begin : g_plain
      assign bus.dout = w_byte;
    end
  endgenerate

  // Fetch FSM and buffer fill; drop remembers a flush seen during the fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_drop       <= 1'b0;
      r_req        <= 1'b0;
      r_tag        <= '0;
      r_sdram_addr <= '0;
      r_line       <= '0;
    end else begin
      if (bus.flush) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cs && !w_hit) begin
            r_state      <= FETCH;
            r_req        <= 1'b1;
            r_sdram_addr <= bus.addr[AW-1:LB];
            r_drop       <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.flush) r_drop <= 1'b1;
          if (bus.data_ok) begin
            r_line  <= bus.sdram_data;
            r_tag   <= r_sdram_addr;
            r_valid <= !r_drop && !bus.flush;
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtpopeye_romrq.sv
// Directed bench for jtpopeye_romrq: plain and descrambled instances share stimulus.
module tb_jtpopeye_romrq;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int unsigned LINE_BYTES = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic cs;
  logic [AW-1:0] addr;
  logic flush;
  logic data_ok;
  logic [LINE_BYTES*DW-1:0] sdram_data;

  int n_vec = 0;
  int n_err = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  jtpopeye_romrq_if #(.AW(AW), .DW(DW), .LINE_BYTES(LINE_BYTES)) if0 ();
  jtpopeye_romrq_if #(.AW(AW), .DW(DW), .LINE_BYTES(LINE_BYTES)) if1 ();

  assign if0.cs = cs;      assign if1.cs = cs;
  assign if0.addr = addr;  assign if1.addr = addr;
  assign if0.flush = flush;   assign if1.flush = flush;
  assign if0.data_ok = data_ok; assign if1.data_ok = data_ok;
  assign if0.sdram_data = sdram_data; assign if1.sdram_data = sdram_data;

  jtpopeye_romrq #(.AW(AW), .DW(DW), .LINE_BYTES(LINE_BYTES), .DESCRAMBLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  jtpopeye_romrq #(.AW(AW), .DW(DW), .LINE_BYTES(LINE_BYTES), .DESCRAMBLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Count sdram_req rising edges, sampled mid-cycle
  always @(negedge clk) begin
    if (if0.sdram_req && !req_prev) req_rises = req_rises + 1;
    req_prev = if0.sdram_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] d, input logic fl);
    data_ok = 1'b1; sdram_data = d; flush = fl;
    tick();
    data_ok = 1'b0; flush = 1'b0;
    #1;
  endtask

  logic [7:0] exp_plain [4];
  logic [7:0] exp_scr   [4];
  int rises0;

  initial begin
    exp_plain[0] = 8'h01; exp_plain[1] = 8'h20; exp_plain[2] = 8'h40; exp_plain[3] = 8'h80;
    exp_scr[0]   = 8'h02; exp_scr[1]   = 8'h10; exp_scr[2]   = 8'h04; exp_scr[3]   = 8'h01;

    rst_n = 1'b0; cs = 1'b0; addr = '0; flush = 1'b0; data_ok = 1'b0; sdram_data = '0;
    tick(); tick();
    check("rst_req", 32'(if0.sdram_req), 32'd0);
    check("rst_wait_n", 32'(if0.wait_n), 32'd1);
    check("rst_dout_scr", 32'(if1.dout), 32'h00);
    rst_n = 1'b1;

    // First miss at 0x0000
    cs = 1'b1; addr = 15'h0000; #1;
    check("miss_wait_n", 32'(if0.wait_n), 32'd0);
    tick();
    check("miss_req", 32'(if0.sdram_req), 32'd1);
    check("miss_saddr", 32'(if0.sdram_addr), 32'h0000);
    tick();
    check("fetch_wait_n", 32'(if0.wait_n), 32'd0);
    fill(32'h8040_2001, 1'b0);
    check("fill_wait_n", 32'(if0.wait_n), 32'd1);
    check("fill_req", 32'(if0.sdram_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      addr = 15'(i); #1;
      check("hit_plain", 32'(if0.dout), 32'(exp_plain[i]));
      check("hit_scr", 32'(if1.dout), 32'(exp_scr[i]));
      check("hit_wait_n", 32'(if0.wait_n), 32'd1);
    end

    // Line boundary 0x0007 -> 0x0008
    addr = 15'h0004; #1;
    check("l1_wait_n", 32'(if0.wait_n), 32'd0);
    tick();
    check("l1_saddr", 32'(if0.sdram_addr), 32'h0001);
    fill(32'h4433_2211, 1'b0);
    addr = 15'h0007; #1;
    check("l7_wait_n", 32'(if0.wait_n), 32'd1);
    check("l7_dout", 32'(if0.dout), 32'h44);
    addr = 15'h0008; #1;
    check("l8_wait_n", 32'(if0.wait_n), 32'd0);
    tick();
    check("l8_req", 32'(if0.sdram_req), 32'd1);
    check("l8_saddr", 32'(if0.sdram_addr), 32'h0002);
    tick();
    check("l8_stall", 32'(if0.wait_n), 32'd0);
    fill(32'h0000_00AA, 1'b0);
    check("l8_filled", 32'(if0.wait_n), 32'd1);
    check("l8_dout", 32'(if0.dout), 32'hAA);

    // Address moves to another line mid-fetch
    rises0 = req_rises;
    addr = 15'h1000; #1;
    tick();
    check("mv_saddr0", 32'(if0.sdram_addr), 32'h0400);
    addr = 15'h2000;
    tick();
    check("mv_hold", 32'(if0.sdram_addr), 32'h0400);
    check("mv_wait_n", 32'(if0.wait_n), 32'd0);
    fill(32'h1234_5678, 1'b0);
    check("mv_miss2", 32'(if0.wait_n), 32'd0);
    check("mv_idle_req", 32'(if0.sdram_req), 32'd0);
    tick();
    check("mv_saddr1", 32'(if0.sdram_addr), 32'h0800);
    addr = 15'h1001; #1;
    check("mv_old_hit", 32'(if0.wait_n), 32'd1);
    check("mv_old_dout", 32'(if0.dout), 32'h56);
    addr = 15'h2000;
    fill(32'h0000_00BB, 1'b0);
    check("mv_filled", 32'(if0.dout), 32'hBB);
    check("mv_rises", 32'(req_rises - rises0), 32'd2);

    // Flush coincident with data_ok
    addr = 15'h0010; #1;
    tick();
    check("fl_saddr", 32'(if0.sdram_addr), 32'h0004);
    fill(32'h0000_00CC, 1'b1);
    check("fl_wait_n", 32'(if0.wait_n), 32'd0);
    tick();
    check("fl_refetch", 32'(if0.sdram_req), 32'd1);
    check("fl_resaddr", 32'(if0.sdram_addr), 32'h0004);
    fill(32'h0000_00CD, 1'b0);
    check("fl_hit", 32'(if0.wait_n), 32'd1);

    // Flush in IDLE on a valid line
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("fi_wait_n", 32'(if0.wait_n), 32'd0);
    tick();
    check("fi_req", 32'(if0.sdram_req), 32'd1);
    fill(32'h0000_00DD, 1'b0);
    check("fi_hit", 32'(if0.dout), 32'hDD);

    // data_ok while IDLE must be ignored
    fill(32'h0000_00EE, 1'b0);
    check("idle_dok", 32'(if0.dout), 32'hDD);

    // Reset during a fetch, then a stale data_ok
    addr = 15'h0020; #1;
    tick();
    check("rf_req", 32'(if0.sdram_req), 32'd1);
    rst_n = 1'b0; cs = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rf_req0", 32'(if0.sdram_req), 32'd0);
    check("rf_saddr0", 32'(if0.sdram_addr), 32'h0000);
    fill(32'hFFFF_FFFF, 1'b0);
    check("rf_req_stay", 32'(if0.sdram_req), 32'd0);
    check("rf_wait_n", 32'(if0.wait_n), 32'd1);
    check("rf_line", 32'(if0.dout), 32'h00);
    cs = 1'b1; addr = 15'h0000; #1;
    check("rf_invalid", 32'(if0.wait_n), 32'd0);
    check("rf_line_scr", 32'(if1.dout), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
